// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with registered reads, zero reg, reset SP and pending scoreboard; optional REGFILE_BYPASS_EN write-to-read forwarding
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int SP_INDEX = 29,
  parameter int SP_RESET = 252
) (
  input  logic              Clk_40,
  input  logic              Reset_40,
  input  logic [ADDR_W-1:0] ReadRegister1_40,
  input  logic [ADDR_W-1:0] ReadRegister2_40,
  input  logic              ReadEnable_40,
  output logic [DATA_W-1:0] ReadData1_40,
  output logic [DATA_W-1:0] ReadData2_40,
  input  logic [ADDR_W-1:0] WriteRegister_40,
  input  logic [DATA_W-1:0] WriteData_40,
  input  logic              RegWrite_40,
  input  logic [ADDR_W-1:0] IssueRegister_40,
  input  logic              IssueValid_40,
  output logic              Pending1_40,
  output logic              Pending2_40,
  output logic              Stall_40
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [DATA_W-1:0]   rd1_q;
  logic [DATA_W-1:0]   rd1_d;
  logic [DATA_W-1:0]   rd2_q;
  logic [DATA_W-1:0]   rd2_d;
  logic                wr_en;
  logic                iss_en;

  // Index 0 is hard-wired zero, so writes and issues to it are dropped here.
  assign wr_en  = RegWrite_40 && (WriteRegister_40 != '0);
  assign iss_en = IssueValid_40 && (IssueRegister_40 != '0);

  // Read capture selection; forwarding only ever matches a nonzero write index.
  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (ReadEnable_40) begin
      rd1_d = (ReadRegister1_40 == '0) ? '0 : regs_q[ReadRegister1_40];
      rd2_d = (ReadRegister2_40 == '0) ? '0 : regs_q[ReadRegister2_40];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (WriteRegister_40 == ReadRegister1_40)) rd1_d = WriteData_40;
      if (wr_en && (WriteRegister_40 == ReadRegister2_40)) rd2_d = WriteData_40;
`endif
    end
  end

  // Scoreboard next state: clear on writeback first, so a same-cycle issue wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_en)  pend_d[WriteRegister_40] = 1'b0;
    if (iss_en) pend_d[IssueRegister_40] = 1'b1;
  end

  // Register storage; reset loads zeros except the stack pointer.
  always_ff @(posedge Clk_40) begin
    if (Reset_40) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
      end
    end else if (wr_en) begin
      regs_q[WriteRegister_40] <= WriteData_40;
    end
  end

  // Read data and pending vector registers.
  always_ff @(posedge Clk_40) begin
    if (Reset_40) begin
      rd1_q  <= '0;
      rd2_q  <= '0;
      pend_q <= '0;
    end else begin
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      pend_q <= pend_d;
    end
  end

  assign ReadData1_40 = rd1_q;
  assign ReadData2_40 = rd2_q;
  assign Pending1_40  = pend_q[ReadRegister1_40];
  assign Pending2_40  = pend_q[ReadRegister2_40];
  assign Stall_40     = ReadEnable_40 && (Pending1_40 || Pending2_40);

endmodule
